// File: rtl/matmul_bt_sched.sv
// Read/MAC/write scheduler for C = A * B^T (i outer, j middle, k inner).
// Optional busy-cycle counter enabled by defining MATMUL_BT_SCHED_PERF_EN.
module matmul_bt_sched #(
  parameter int DIM_W   = 8,
  parameter int AW      = 16,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic             hold,
  output logic             a_rd_en,
  output logic [AW-1:0]    a_rd_addr,
  output logic             b_rd_en,
  output logic [AW-1:0]    b_rd_addr,
  output logic             mac_en,
  output logic             mac_first,
  output logic             mac_last,
  output logic             c_wr_en,
  output logic [AW-1:0]    c_wr_addr,
  output logic             busy,
  output logic             done,
  output logic [31:0]      perf_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic [DIM_W-1:0] m_q, n_q, k_q;
  logic [DIM_W-1:0] i_q, j_q, kk_q;
  logic             rd_en, k_wrap, j_wrap, i_wrap, last_rd, cfg_zero, accept;
  logic             busy_int;
  logic [AW-1:0]    a_addr, b_addr, c_addr_now;

  // vld_pipe[0] is the mac_last stage; vld_pipe[MAC_LAT] is the C write strobe
  logic                       mac_en_q, mac_first_q;
  logic [MAC_LAT:0]           vld_pipe;
  logic [MAC_LAT:0][AW-1:0]   addr_pipe;

  assign cfg_zero = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);
  assign accept   = (state_q == IDLE) && start;
  assign rd_en    = (state_q == RUN) && !hold;
  assign k_wrap   = (kk_q == k_q - DIM_W'(1));
  assign j_wrap   = (j_q  == n_q - DIM_W'(1));
  assign i_wrap   = (i_q  == m_q - DIM_W'(1));
  assign last_rd  = rd_en && k_wrap && j_wrap && i_wrap;
  assign busy_int = (state_q == RUN) || (state_q == DRAIN);

  assign a_addr     = AW'(i_q) * AW'(k_q) + AW'(kk_q);
  assign b_addr     = AW'(j_q) * AW'(k_q) + AW'(kk_q);
  assign c_addr_now = AW'(i_q) * AW'(n_q) + AW'(j_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = cfg_zero ? DONE : RUN;
      RUN:   if (last_rd) state_d = DRAIN;
      // the last write is the only one left once the earlier stages are empty
      DRAIN: if (vld_pipe[MAC_LAT] && (vld_pipe[MAC_LAT-1:0] == '0)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q  <= '0;
      n_q  <= '0;
      k_q  <= '0;
      i_q  <= '0;
      j_q  <= '0;
      kk_q <= '0;
    end else if (accept) begin
      m_q  <= cfg_m;
      n_q  <= cfg_n;
      k_q  <= cfg_k;
      i_q  <= '0;
      j_q  <= '0;
      kk_q <= '0;
    end else if (rd_en) begin
      kk_q <= k_wrap ? '0 : kk_q + DIM_W'(1);
      if (k_wrap) j_q <= j_wrap ? '0 : j_q + DIM_W'(1);
      if (k_wrap && j_wrap) i_q <= i_wrap ? '0 : i_q + DIM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      vld_pipe    <= '0;
      addr_pipe   <= '0;
    end else begin
      mac_en_q    <= rd_en;
      mac_first_q <= rd_en && (kk_q == '0);
      vld_pipe    <= {vld_pipe[MAC_LAT-1:0], rd_en && k_wrap};
      addr_pipe   <= {addr_pipe[MAC_LAT-1:0], c_addr_now};
    end
  end

  assign a_rd_en   = rd_en & ~rst;
  assign b_rd_en   = rd_en & ~rst;
  assign a_rd_addr = rst ? '0 : a_addr;
  assign b_rd_addr = rst ? '0 : b_addr;
  assign mac_en    = mac_en_q & ~rst;
  assign mac_first = mac_first_q & ~rst;
  assign mac_last  = vld_pipe[0] & ~rst;
  assign c_wr_en   = vld_pipe[MAC_LAT] & ~rst;
  assign c_wr_addr = rst ? '0 : addr_pipe[MAC_LAT];
  assign busy      = busy_int & ~rst;
  assign done      = (state_q == DONE) & ~rst;

`ifdef MATMUL_BT_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                            perf_q <= '0;
    else if (accept)                    perf_q <= '0;
    else if (busy_int && perf_q != '1)  perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = rst ? '0 : perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_bt_sched.sv
// Self-checking bench for matmul_bt_sched: directed scenarios plus randomized jobs
// compared cycle by cycle against a loop-order reference model.
module tb_matmul_bt_sched;
  localparam int DIM_W = 8;
  localparam int AW    = 16;
  localparam int ML    = 1;
  localparam int NC    = 256;

  logic clk = 1'b0;
  logic rst, start, hold;
  logic [DIM_W-1:0] cfg_m, cfg_n, cfg_k;
  logic a_rd_en, b_rd_en, mac_en, mac_first, mac_last, c_wr_en, busy, done;
  logic [AW-1:0] a_rd_addr, b_rd_addr, c_wr_addr;
  logic [31:0] perf_cycles;

  int checks = 0;
  int failures = 0;

  bit exp_rd[NC], exp_mac[NC], exp_first[NC], exp_last[NC], exp_wr[NC], exp_busy[NC], exp_done[NC];
  int exp_a[NC], exp_b[NC], exp_c[NC];
  bit hv[NC];
  int cap_a[$], cap_b[$], cap_rcyc[$], cap_c[$], cap_ccyc[$], cap_done[$];

  always #5 clk = ~clk;

  matmul_bt_sched #(.DIM_W(DIM_W), .AW(AW), .MAC_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .hold(hold),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
    .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr),
    .busy(busy), .done(done), .perf_cycles(perf_cycles)
  );

  // Reference: walk the flat element index in i/j/k order, skipping held cycles.
  task automatic model(input int m, input int n, input int k, output int last_cyc, output int nbusy);
    int idx, c, lr, fw, ii, jj, kk;
    for (int x = 0; x < NC; x++) begin
      exp_rd[x] = 0; exp_mac[x] = 0; exp_first[x] = 0; exp_last[x] = 0;
      exp_wr[x] = 0; exp_busy[x] = 0; exp_done[x] = 0;
      exp_a[x] = 0; exp_b[x] = 0; exp_c[x] = 0;
    end
    if (m == 0 || n == 0 || k == 0) begin
      exp_done[1] = 1;
      last_cyc = 1;
      nbusy = 0;
    end else begin
      idx = 0; c = 1; lr = 1;
      while (idx < m * n * k && c < NC - ML - 8) begin
        if (!hv[c]) begin
          ii = idx / (n * k); jj = (idx / k) % n; kk = idx % k;
          exp_rd[c] = 1;
          exp_a[c] = ii * k + kk;
          exp_b[c] = jj * k + kk;
          exp_mac[c+1] = 1;
          exp_first[c+1] = (kk == 0);
          exp_last[c+1] = (kk == k - 1);
          if (kk == k - 1) begin
            exp_wr[c+1+ML] = 1;
            exp_c[c+1+ML] = ii * n + jj;
          end
          lr = c;
          idx++;
        end
        c++;
      end
      fw = lr + 1 + ML;
      for (int x = 1; x <= fw; x++) exp_busy[x] = 1;
      exp_done[fw+1] = 1;
      last_cyc = fw + 1;
      nbusy = fw;
    end
  endtask

  // Runs one job starting at cycle 0; caller is at posedge+1 with the DUT idle.
  task automatic run_job(input int m, input int n, input int k, input int restart_cyc);
    int last_cyc, nbusy, exp_perf;
    logic [7:0] obs, expv;
    model(m, n, k, last_cyc, nbusy);
    cap_a.delete(); cap_b.delete(); cap_rcyc.delete();
    cap_c.delete(); cap_ccyc.delete(); cap_done.delete();
    for (int c = 0; c <= last_cyc + 3; c++) begin
      start = (c == 0) || (c == restart_cyc);
      if (c == 0) begin
        cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_k = DIM_W'(k);
      end else begin
        cfg_m = DIM_W'($urandom); cfg_n = DIM_W'($urandom); cfg_k = DIM_W'($urandom);
      end
      hold = hv[c];
      @(negedge clk);
      obs  = {a_rd_en, b_rd_en, mac_en, mac_first, mac_last, c_wr_en, busy, done};
      expv = {exp_rd[c], exp_rd[c], exp_mac[c], exp_first[c], exp_last[c], exp_wr[c], exp_busy[c], exp_done[c]};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL ctrl mnk=%0d,%0d,%0d cyc=%0d got=%b exp=%b", m, n, k, c, obs, expv);
      end
      if (exp_rd[c]) begin
        checks++;
        if (a_rd_addr !== AW'(exp_a[c]) || b_rd_addr !== AW'(exp_b[c])) begin
          failures++;
          $display("FAIL rd_addr cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d", c, a_rd_addr, b_rd_addr, exp_a[c], exp_b[c]);
        end
      end
      if (exp_wr[c]) begin
        checks++;
        if (c_wr_addr !== AW'(exp_c[c])) begin
          failures++;
          $display("FAIL c_wr_addr cyc=%0d got=%0d exp=%0d", c, c_wr_addr, exp_c[c]);
        end
      end
      if (a_rd_en) begin cap_a.push_back(int'(a_rd_addr)); cap_b.push_back(int'(b_rd_addr)); cap_rcyc.push_back(c); end
      if (c_wr_en) begin cap_c.push_back(int'(c_wr_addr)); cap_ccyc.push_back(c); end
      if (done) cap_done.push_back(c);
      @(posedge clk); #1;
    end
    start = 0; hold = 0;
`ifdef MATMUL_BT_SCHED_PERF_EN
    exp_perf = nbusy;
`else
    exp_perf = 0;
`endif
    checks++;
    if (perf_cycles !== 32'(exp_perf)) begin
      failures++;
      $display("FAIL perf_cycles mnk=%0d,%0d,%0d got=%0d exp=%0d", m, n, k, perf_cycles, exp_perf);
    end
  endtask

  task automatic clear_hold();
    for (int x = 0; x < NC; x++) hv[x] = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; hold = 0; cfg_m = '0; cfg_n = '0; cfg_k = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({a_rd_en, b_rd_en, mac_en, mac_first, mac_last, c_wr_en, busy, done} !== 8'b0 ||
          a_rd_addr !== '0 || b_rd_addr !== '0 || c_wr_addr !== '0 || perf_cycles !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got en=%b a=%0d b=%0d c=%0d perf=%0d exp all 0", c,
                 {a_rd_en, b_rd_en, mac_en, mac_first, mac_last, c_wr_en, busy, done},
                 a_rd_addr, b_rd_addr, c_wr_addr, perf_cycles);
      end
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic check_basic_trace(input string tag, input int done_cyc);
    int ea[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int eb[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ecc[4] = '{4, 6, 8, 10};
    checks++;
    if (cap_a.size() != 8 || cap_c.size() != 4 || cap_done.size() != 1) begin
      failures++;
      $display("FAIL %s counts got rd=%0d wr=%0d done=%0d exp 8 4 1", tag, cap_a.size(), cap_c.size(), cap_done.size());
    end else begin
      for (int x = 0; x < 8; x++) begin
        checks++;
        if (cap_a[x] != ea[x] || cap_b[x] != eb[x]) begin
          failures++;
          $display("FAIL %s rd%0d got a=%0d b=%0d exp a=%0d b=%0d", tag, x, cap_a[x], cap_b[x], ea[x], eb[x]);
        end
      end
      for (int x = 0; x < 4; x++) begin
        checks++;
        if (cap_c[x] != x || cap_ccyc[x] != ecc[x]) begin
          failures++;
          $display("FAIL %s wr%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d", tag, x, cap_c[x], cap_ccyc[x], x, ecc[x]);
        end
      end
      checks++;
      if (cap_done[0] != done_cyc) begin
        failures++;
        $display("FAIL %s done_cycle got=%0d exp=%0d", tag, cap_done[0], done_cyc);
      end
    end
  endtask

  task automatic test_basic();
    clear_hold();
    run_job(2, 2, 2, 0);
    check_basic_trace("basic", 11);
  endtask

  task automatic test_zero_dim();
    clear_hold();
    run_job(2, 2, 0, 0);
    checks++;
    if (cap_a.size() != 0 || cap_c.size() != 0 || cap_done.size() != 1 || cap_done[0] != 1) begin
      failures++;
      $display("FAIL zero_dim got rd=%0d wr=%0d ndone=%0d exp 0 0 1 at cyc 1", cap_a.size(), cap_c.size(), cap_done.size());
    end
    run_job(0, 3, 1, 0);
    run_job(4, 0, 2, 0);
  endtask

  task automatic test_hold();
    clear_hold();
    hv[3] = 1; hv[4] = 1; hv[5] = 1;
    run_job(2, 2, 2, 0);
    checks++;
    if (cap_rcyc.size() < 3 || cap_rcyc[2] != 6 || cap_a[2] != 0 || cap_b[2] != 2 ||
        cap_done.size() != 1 || cap_done[0] != 14) begin
      failures++;
      $display("FAIL hold_resume got nrd=%0d ndone=%0d exp third read a=0 b=2 at cyc 6, done at 14",
               cap_rcyc.size(), cap_done.size());
    end
    clear_hold();
  endtask

  task automatic test_restart();
    clear_hold();
    run_job(2, 2, 2, 5);
    check_basic_trace("restart", 11);
  endtask

  task automatic test_reset_mid();
    clear_hold();
    start = 1; cfg_m = 2; cfg_n = 2; cfg_k = 2; hold = 0;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checks++;
    if (a_rd_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_running got rd=%b busy=%b exp 1 1", a_rd_en, busy);
    end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 5; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if ({a_rd_en, b_rd_en, mac_en, mac_first, mac_last, c_wr_en, busy, done} !== 8'b0 ||
          a_rd_addr !== '0 || b_rd_addr !== '0 || c_wr_addr !== '0 || perf_cycles !== '0) begin
        failures++;
        $display("FAIL reset_mid_quiet cyc=%0d got en=%b a=%0d b=%0d c=%0d perf=%0d exp all 0", c,
                 {a_rd_en, b_rd_en, mac_en, mac_first, mac_last, c_wr_en, busy, done},
                 a_rd_addr, b_rd_addr, c_wr_addr, perf_cycles);
      end
      @(posedge clk); #1;
    end
    run_job(2, 2, 2, 0);
    check_basic_trace("after_reset", 11);
  endtask

  task automatic test_k1();
    clear_hold();
    run_job(3, 2, 1, 0);
    run_job(1, 1, 1, 0);
  endtask

  task automatic test_random();
    int m, n, k, rs;
    for (int t = 0; t < 25; t++) begin
      clear_hold();
      m = $urandom_range(1, 4); n = $urandom_range(1, 4); k = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) k = 0;
      for (int x = 1; x < 100; x++) hv[x] = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, m * n * k) : 0;
      run_job(m, n, k, rs);
    end
    clear_hold();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_dim();
    test_hold();
    test_restart();
    test_reset_mid();
    test_k1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matmul_bt_sched.md
MATMUL_BT_SCHED -- requirements
Module: matmul_bt_sched

Interface
REQ-001 SHALL have parameter DIM_W, default 8: width of each runtime dimension field.
REQ-002 SHALL have parameter AW, default 16: width of every address output.
REQ-003 SHALL have parameter MAC_LAT, default 1, minimum 1: cycles from mac_last to its result being valid.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-007 SHALL have ports cfg_m, cfg_n, cfg_k, input, DIM_W bits each: dimensions, C is MxN, A is MxK, B is stored transposed as NxK.
REQ-008 SHALL have port hold, input, 1 bit: freezes read issue and loop counters.
REQ-009 SHALL have ports a_rd_en / a_rd_addr, output, 1 / AW bits: A read request, row-major, address i*K+k.
REQ-010 SHALL have ports b_rd_en / b_rd_addr, output, 1 / AW bits: B^T read request, row-major, address j*K+k.
REQ-011 SHALL have ports mac_en, mac_first, mac_last, output, 1 bit each: MAC control, aligned with read data one cycle after the read.
REQ-012 SHALL have ports c_wr_en / c_wr_addr, output, 1 / AW bits: C write strobe and address, i*N+j.
REQ-013 SHALL have ports busy and done, output, 1 bit each: busy = job active; done = one-cycle completion pulse.
REQ-014 SHALL have port perf_cycles, output, 32 bits: busy-cycle count (see Configuration).

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE SHALL go to RUN when start=1; cfg_* SHALL be latched on that same cycle and ignored afterwards.
REQ-017 When start is sampled with any cfg field equal to zero, SHALL go to DONE, issue no reads and produce no writes.
REQ-018 In RUN with hold=0, SHALL assert a_rd_en and b_rd_en together once per cycle.
REQ-019 Loop order SHALL be i outer, j middle, k inner.
REQ-020 Wrap rules: k==K-1 wraps k to 0 and increments j; j==N-1 also wraps j to 0 and increments i.
REQ-021 In RUN with hold=1, SHALL deassert the read enables and freeze i, j and k; the in-flight pipeline SHALL keep advancing.
REQ-022 mac_en SHALL equal the read enables delayed by one cycle.
REQ-023 mac_first SHALL mark k==0 and mac_last SHALL mark k==K-1, with the same one-cycle delay as mac_en.
REQ-024 c_wr_en SHALL pulse exactly MAC_LAT cycles after each mac_last, with c_wr_addr = i*N+j of that element.
REQ-025 After the final read (i=M-1, j=N-1, k=K-1), SHALL go RUN to DRAIN.
REQ-026 DRAIN SHALL go to DONE on the cycle of the final c_wr_en; DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in RUN and DRAIN only; done SHALL never be high while busy is high.
REQ-028 Latency: with no hold, start at cycle t gives reads at t+1 .. t+MNK, final c_wr_en at t+MNK+1+MAC_LAT, and done at t+MNK+2+MAC_LAT.
REQ-029 start outside IDLE SHALL be ignored with no effect on the current job.
REQ-030 Address arithmetic SHALL be unsigned, truncated to AW bits; products wider than AW wrap silently.
REQ-031 K=1 SHALL assert mac_first and mac_last together on every beat.

Reset
REQ-032 While rst=1, SHALL force state IDLE and clear all counters and the delay pipeline.
REQ-033 While rst=1, SHALL drive every output to 0, including both address outputs and perf_cycles.
REQ-034 Reset asserted mid-job SHALL abort the job: no further reads or writes, and no done pulse.

Configuration
REQ-035 Macro MATMUL_BT_SCHED_PERF_EN defined: perf_cycles SHALL clear on accepted start and increment on every busy cycle, saturating at 2^32-1.
REQ-036 perf_cycles SHALL hold its value after done until the next accepted start.
REQ-037 Macro MATMUL_BT_SCHED_PERF_EN not defined: perf_cycles SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-038 Scenario basic: M=N=K=2, MAC_LAT=1, start at cycle 0.
- a_rd_addr sequence SHALL be 0,1,0,1,2,3,2,3.
- b_rd_addr sequence SHALL be 0,1,2,3,0,1,2,3.
- c_wr_addr SHALL be 0,1,2,3 at cycles 4,6,8,10.
- done SHALL pulse at cycle 11.
REQ-039 Scenario zero dimension: cfg_k=0 -> no rd_en and no c_wr_en; done SHALL pulse at cycle 1 and busy SHALL stay 0.
REQ-040 Scenario hold: as REQ-038 with hold=1 for cycles 3-5 -> reads resume with a=0,b=2 at cycle 6; done SHALL slip by exactly 3 cycles to cycle 14.
REQ-041 Scenario restart: start pulsed again at cycle 5 of REQ-038 -> ignored; addresses and done timing SHALL be unchanged.
REQ-042 Scenario reset mid-job: rst at cycle 4 of REQ-038 -> all outputs 0 from cycle 5, no done pulse, and a fresh start then runs REQ-038 cleanly.
REQ-043 Scenario performance counter: with MATMUL_BT_SCHED_PERF_EN defined, REQ-038 SHALL leave perf_cycles = 10 after done; with it undefined, perf_cycles SHALL read 0.
